// File: rtl/adc_spi_slave_model.sv
// Multi-channel SPI ADC slave emulator (AD7264-style) running entirely on clk.
// Oversamples sclk/ss_n/mosi, receives a command word, three-states for a gap,
// then shifts one conversion word per channel out on parallel miso lines.
// Ports:
//   clk, resetn          system clock, async active-low reset
//   sclk, ss_n, mosi     SPI pins from the master (sclk idles high, falling-edge shifting)
//   miso, miso_oe        per-channel serial data and output enable
//   load_data/valid/ready conversion-word staging port (valid/ready)
//   rx_word, rx_valid    last complete command word and its update pulse
//   stale                current TX frame is reusing the previous words
//   frame_err            pulse when ss_n rises mid-frame
module adc_spi_slave_model #(
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned RX_BITS     = 16,
    parameter int unsigned TRI_BITS    = 2,
    parameter int unsigned TX_BITS     = 14,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      sclk,
    input  logic                      ss_n,
    input  logic                      mosi,
    output logic [NUM_CH-1:0]         miso,
    output logic [NUM_CH-1:0]         miso_oe,
    input  logic [NUM_CH*TX_BITS-1:0] load_data,
    input  logic                      load_valid,
    output logic                      load_ready,
    output logic [RX_BITS-1:0]        rx_word,
    output logic                      rx_valid,
    output logic                      stale,
    output logic                      frame_err
);

    localparam int unsigned FRAME = RX_BITS + TRI_BITS + TX_BITS + 1;
    localparam int unsigned CW    = $clog2(FRAME + 1);
    localparam int unsigned DW    = NUM_CH * TX_BITS;

    localparam logic [CW-1:0] CNT_RX_LAST = CW'(RX_BITS - 1);
    localparam logic [CW-1:0] CNT_TRI0    = CW'(RX_BITS);
    localparam logic [CW-1:0] CNT_LOAD    = CW'(RX_BITS + TRI_BITS - 1);
    localparam logic [CW-1:0] CNT_TX0     = CW'(RX_BITS + TRI_BITS);
    localparam logic [CW-1:0] CNT_LAST_SH = CW'(FRAME - 2);
    localparam logic [CW-1:0] CNT_HOLD    = CW'(FRAME - 1);
    localparam logic [CW-1:0] CNT_DONE    = CW'(FRAME);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RX   = 3'd1,
        TRI  = 3'd2,
        TX   = 3'd3,
        HOLD = 3'd4,
        DONE = 3'd5
    } state_t;

    // Phase of the frame implied by a bit count and the select level.
    function automatic state_t decode(input logic [CW-1:0] c, input logic deselected);
        state_t s;
        if (deselected)          s = IDLE;
        else if (c < CNT_TRI0)   s = RX;
        else if (c < CNT_TX0)    s = TRI;
        else if (c < CNT_HOLD)   s = TX;
        else if (c == CNT_HOLD)  s = HOLD;
        else                     s = DONE;
        return s;
    endfunction

    // ---------------------------------------------------------------
    // Pin synchronisers and edge detection
    // ---------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sclk_sr, ss_sr, mosi_sr;
    logic                   sclk_d1, ss_d1;
    logic                   sclk_s, ss_s, mosi_s;
    logic                   fe, ss_rise;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sclk_sr <= '0;
            ss_sr   <= '0;
            mosi_sr <= '0;
            sclk_d1 <= 1'b0;
            ss_d1   <= 1'b0;
        end else begin
            sclk_sr <= {sclk_sr[SYNC_STAGES-2:0], sclk};
            ss_sr   <= {ss_sr[SYNC_STAGES-2:0], ss_n};
            mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], mosi};
            sclk_d1 <= sclk_s;
            ss_d1   <= ss_s;
        end
    end

    assign sclk_s  = sclk_sr[SYNC_STAGES-1];
    assign ss_s    = ss_sr[SYNC_STAGES-1];
    assign mosi_s  = mosi_sr[SYNC_STAGES-1];
    assign fe      = sclk_d1 & ~sclk_s & ~ss_s;
    assign ss_rise = ~ss_d1 & ss_s;

    // ---------------------------------------------------------------
    // State register (bit counter plus decoded phase)
    // ---------------------------------------------------------------
    logic [CW-1:0] cnt_q, cnt_d;
    state_t        state_q, state_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q   <= '0;
            state_q <= IDLE;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    // Next state: counter clears while deselected and saturates at DONE.
    always_comb begin
        cnt_d = cnt_q;
        if (ss_s)
            cnt_d = '0;
        else if (fe && (cnt_q != CNT_DONE))
            cnt_d = cnt_q + CW'(1);
        state_d = decode(cnt_d, ss_s);
    end

    // ---------------------------------------------------------------
    // Output / datapath next values
    // ---------------------------------------------------------------
    logic [RX_BITS-1:0] rx_sr_q, rx_sr_d, rx_word_d;
    logic               rx_pend_q, rx_pend_d;
    logic [DW-1:0]      stg_q, stg_d, last_q, last_d, sh_q, sh_d;
    logic               full_q, full_d;
    logic               oe_q, oe_d;
    logic [NUM_CH-1:0]  miso_d;
    logic               stale_d, frame_err_d;
    logic               rx_shift, rx_last, tx_load, tx_shift, copy_now, accept, abort;

    // Strobes are taken from the pre-increment count so each fe acts on the
    // phase it leaves; a TX->HOLD edge does not shift so the LSB is held.
    always_comb begin
        rx_shift    = fe && (cnt_q < CNT_TRI0);
        rx_last     = fe && (cnt_q == CNT_RX_LAST);
        tx_load     = fe && (cnt_q == CNT_LOAD);
        tx_shift    = fe && (state_q == TX) && (cnt_q != CNT_LAST_SH);
        copy_now    = tx_load && full_q;
        accept      = load_valid && load_ready;
        abort       = ss_rise && (cnt_q != '0) && (state_q != DONE);
        oe_d        = (state_d == TX) || (state_d == HOLD);
        frame_err_d = abort;

        rx_sr_d = rx_sr_q;
        if (ss_s)
            rx_sr_d = '0;
        else if (rx_shift)
            rx_sr_d = {rx_sr_q[RX_BITS-2:0], mosi_s};
        rx_word_d = rx_last ? rx_sr_d : rx_word;
        rx_pend_d = rx_last;

        // A same-cycle load and copy: copy takes the old word, new word lands.
        stg_d  = accept ? load_data : stg_q;
        full_d = full_q;
        if (accept)
            full_d = 1'b1;
        else if (copy_now)
            full_d = 1'b0;
        last_d = copy_now ? stg_q : last_q;

        sh_d = sh_q;
        if (tx_load)
            sh_d = full_q ? stg_q : last_q;
        else if (tx_shift)
            for (int unsigned k = 0; k < NUM_CH; k++)
                sh_d[k*TX_BITS +: TX_BITS] = sh_q[k*TX_BITS +: TX_BITS] << 1;

        miso_d = '0;
        for (int unsigned k = 0; k < NUM_CH; k++)
            miso_d[k] = oe_d & sh_d[k*TX_BITS + TX_BITS - 1];

        stale_d = stale;
        if (ss_s)
            stale_d = 1'b0;
        else if (tx_load)
            stale_d = ~full_q;
    end

    assign load_ready = ~full_q | copy_now;
    assign miso_oe    = {NUM_CH{oe_q}};

    // Datapath and output registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_sr_q   <= '0;
            rx_word   <= '0;
            rx_pend_q <= 1'b0;
            rx_valid  <= 1'b0;
            stg_q     <= '0;
            full_q    <= 1'b0;
            last_q    <= '0;
            sh_q      <= '0;
            miso      <= '0;
            oe_q      <= 1'b0;
            stale     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_sr_q   <= rx_sr_d;
            rx_word   <= rx_word_d;
            rx_pend_q <= rx_pend_d;
            rx_valid  <= rx_pend_q;
            stg_q     <= stg_d;
            full_q    <= full_d;
            last_q    <= last_d;
            sh_q      <= sh_d;
            miso      <= miso_d;
            oe_q      <= oe_d;
            stale     <= stale_d;
            frame_err <= frame_err_d;
        end
    end

endmodule
